// File: rtl/trigger_ctrl_pkg.sv
// Shared types, widths and the round-robin search helper for the trigger controller.
package trigger_ctrl_pkg;

    localparam int COUNT_WIDTH = 32;
    localparam int MAX_SOURCES = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        DEADTIME = 2'd2
    } state_t;

    // First set bit of req scanning upward from last+1 and wrapping at n.
    // Returns last when nothing is requested; callers only use the result
    // when at least one request bit is set.
    function automatic logic [3:0] rr_next(input logic [MAX_SOURCES-1:0] req,
                                           input logic [3:0]             last,
                                           input int unsigned            n);
        logic        found;
        int unsigned cand;
        rr_next = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= MAX_SOURCES; k++) begin
            cand = (32'(last) + k) % n;
            if (!found && (k <= n) && req[cand[3:0]]) begin
                rr_next = cand[3:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/trigger_controller_prescaler.sv
// Per-source rising-edge detector and event prescaler; emits a registered one-cycle pulse.
module trigger_prescaler
    import trigger_ctrl_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trig_i,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      event_o
);

    logic                      trig_d_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      fire_q, fire_d;
    logic                      edge_det;

    assign edge_det = trig_i & ~trig_d_q;

    // Count events while enabled; every (P+1)th event passes. A counter that
    // has overtaken a freshly lowered P passes on its next event instead of stalling.
    always_comb begin
        cnt_d  = cnt_q;
        fire_d = 1'b0;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (edge_det) begin
            if (cnt_q >= prescale_i) begin
                cnt_d  = '0;
                fire_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Edge history, prescale counter and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d_q <= 1'b0;
            cnt_q    <= '0;
            fire_q   <= 1'b0;
        end else begin
            trig_d_q <= trig_i;
            cnt_q    <= cnt_d;
            fire_q   <= fire_d;
        end
    end

    assign event_o = fire_q;

endmodule

// File: rtl/trigger_controller.sv
// Round-robin trigger arbiter with pending latches, valid/ready issue, deadtime and counters.
module trigger_controller
    import trigger_ctrl_pkg::*;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int PRESCALE_WIDTH = 16,
    parameter int DEADTIME_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SOURCES-1:0]               trig_in,
    input  logic [NUM_SOURCES-1:0]               enable,
    input  logic [NUM_SOURCES*PRESCALE_WIDTH-1:0] prescale,
    input  logic [DEADTIME_WIDTH-1:0]            deadtime,
    input  logic                                 daq_busy,
    output logic                                 trig_valid,
    input  logic                                 trig_ready,
    output logic [$clog2(NUM_SOURCES)-1:0]       trig_source,
    output logic [NUM_SOURCES-1:0]               trig_mask,
    output logic [COUNT_WIDTH-1:0]               accepted_count,
    output logic [COUNT_WIDTH-1:0]               dropped_count
);

    localparam int SW = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0]    fire;
    state_t                    state_q, state_d;
    logic [NUM_SOURCES-1:0]    pending_q, pending_d;
    logic [NUM_SOURCES-1:0]    grant_onehot, drop_vec;
    logic [SW-1:0]             last_grant_q, last_grant_d;
    logic [SW-1:0]             src_q, src_d, grant_idx;
    logic [NUM_SOURCES-1:0]    mask_q, mask_d;
    logic [DEADTIME_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]    acc_q, acc_d, drop_q, drop_d;
    logic                      grant_vld;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
        trigger_prescaler #(
            .PRESCALE_WIDTH(PRESCALE_WIDTH)
        ) u_prescaler (
            .clk       (clk),
            .rst       (rst),
            .trig_i    (trig_in[i]),
            .enable_i  (enable[i]),
            .prescale_i(prescale[i*PRESCALE_WIDTH +: PRESCALE_WIDTH]),
            .event_o   (fire[i])
        );
    end

    assign grant_idx = SW'(rr_next(MAX_SOURCES'(pending_q), 4'(last_grant_q), NUM_SOURCES));

    // FSM next state: grant from IDLE, hold request in ISSUE, count down deadtime.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        grant_vld    = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|pending_q) && !daq_busy) begin
                    grant_vld    = 1'b1;
                    src_d        = grant_idx;
                    mask_d       = pending_q;
                    last_grant_d = grant_idx;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (trig_ready) begin
                    acc_d = acc_q + 1'b1;
                    if (deadtime == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = deadtime;
                        state_d = DEADTIME;
                    end
                end
            end
            DEADTIME: begin
                if (cnt_q <= DEADTIME_WIDTH'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending latches: a new event survives a same-cycle grant; an event onto
    // a still-pending source is counted as dropped.
    always_comb begin
        grant_onehot = '0;
        drop_vec     = '0;
        pending_d    = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            grant_onehot[i] = grant_vld && (grant_idx == SW'(i));
            drop_vec[i]     = enable[i] & fire[i] & pending_q[i] & ~grant_onehot[i];
            pending_d[i]    = enable[i] & (fire[i] | (pending_q[i] & ~grant_onehot[i]));
        end
        drop_d = drop_q + COUNT_WIDTH'($countones(drop_vec));
    end

    // Controller state registers; last_grant resets so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            last_grant_q <= SW'(NUM_SOURCES - 1);
            src_q        <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            drop_q       <= drop_d;
        end
    end

    assign trig_valid     = (state_q == ISSUE);
    assign trig_source    = src_q;
    assign trig_mask      = mask_q;
    assign accepted_count = acc_q;
    assign dropped_count  = drop_q;

endmodule

// File: tb/tb_trigger_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_trigger_controller;

    localparam int NS = 4;
    localparam int PW = 16;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    trig_in;
    logic [NS-1:0]    enable;
    logic [NS*PW-1:0] prescale;
    logic [DW-1:0]    deadtime;
    logic             daq_busy;
    logic             trig_valid;
    logic             trig_ready;
    logic [1:0]       trig_source;
    logic [NS-1:0]    trig_mask;
    logic [31:0]      accepted_count;
    logic [31:0]      dropped_count;

    trigger_controller #(
        .NUM_SOURCES   (NS),
        .PRESCALE_WIDTH(PW),
        .DEADTIME_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trig_in       (trig_in),
        .enable        (enable),
        .prescale      (prescale),
        .deadtime      (deadtime),
        .daq_busy      (daq_busy),
        .trig_valid    (trig_valid),
        .trig_ready    (trig_ready),
        .trig_source   (trig_source),
        .trig_mask     (trig_mask),
        .accepted_count(accepted_count),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cyc = 0;
    int          m_ready_at;
    bit [NS-1:0] m_prev, m_fdly, m_pend, m_mask;
    int          m_ev [NS];
    bit          m_issue;
    int          m_src, m_last;
    bit [31:0]   m_acc, m_drop;

    always @(posedge clk) begin : model
        int          g;
        int          idx;
        bit [NS-1:0] nf;
        bit          keep;
        if (rst) begin
            m_prev = '0; m_fdly = '0; m_pend = '0; m_mask = '0;
            for (int i = 0; i < NS; i++) m_ev[i] = 0;
            m_issue = 1'b0; m_src = 0; m_last = NS - 1;
            m_acc = '0; m_drop = '0; m_ready_at = 0;
        end else begin
            g = -1;
            if (!m_issue && (m_cyc >= m_ready_at) && !daq_busy) begin
                for (int k = 1; k <= NS; k++) begin
                    idx = (m_last + k) % NS;
                    if (g < 0 && m_pend[idx]) g = idx;
                end
            end
            nf = '0;
            for (int i = 0; i < NS; i++) begin
                if (!enable[i]) m_ev[i] = 0;
                else if (trig_in[i] && !m_prev[i]) begin
                    m_ev[i]++;
                    if (m_ev[i] >= int'(prescale[i*PW +: PW]) + 1) begin
                        nf[i] = 1'b1;
                        m_ev[i] = 0;
                    end
                end
                m_prev[i] = trig_in[i];
            end
            if (m_issue && trig_ready) begin
                m_acc++;
                m_issue = 1'b0;
                m_ready_at = m_cyc + int'(deadtime) + 1;
            end else if (g >= 0) begin
                m_issue = 1'b1;
                m_src   = g;
                m_mask  = m_pend;
                m_last  = g;
            end
            for (int i = 0; i < NS; i++) begin
                keep = m_pend[i] && (i != g);
                if (!enable[i]) m_pend[i] = 1'b0;
                else begin
                    if (m_fdly[i] && keep) m_drop++;
                    m_pend[i] = m_fdly[i] || keep;
                end
            end
            m_fdly = nf;
        end
        m_cyc++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", 32'(trig_valid), 32'(m_issue));
            if (m_issue) begin
                chk("source", 32'(trig_source), 32'(m_src));
                chk("mask", 32'(trig_mask), 32'(m_mask));
            end
            chk("accepted", accepted_count, m_acc);
            chk("dropped", dropped_count, m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        trig_in = m;
        tick();
        trig_in = '0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!trig_valid && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(trig_valid), 32'd1);
    endtask

    int          a0, d0, nv, nh, gap;
    logic [1:0]  s_hold;
    logic [3:0]  m_hold;
    int          rr_src [8];
    int          rr_msk [8];
    int          hs_cyc [$];

    initial begin
        rst = 1'b1; trig_in = '0; enable = '1; prescale = '0;
        deadtime = '0; daq_busy = 1'b0; trig_ready = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_valid", 32'(trig_valid), 0);
        chk("rst_source", 32'(trig_source), 0);
        chk("rst_mask", 32'(trig_mask), 0);
        chk("rst_acc", accepted_count, 0);
        chk("rst_drop", dropped_count, 0);
        rst = 1'b0;
        tick();

        // Single source latency
        trig_in = 4'b0100;
        tick();
        trig_in = '0;
        tick();
        chk("t1_valid_early", 32'(trig_valid), 0);
        tick();
        chk("t1_valid", 32'(trig_valid), 1);
        chk("t1_source", 32'(trig_source), 2);
        chk("t1_mask", 32'(trig_mask), 32'b0100);
        tick();
        chk("t1_valid_off", 32'(trig_valid), 0);
        chk("t1_acc", accepted_count, 1);

        // Prescale P=3 over 12 edges, then one long level with P=0
        prescale[0 +: PW] = 16'd3;
        a0 = int'(accepted_count);
        repeat (12) begin
            trig_in = 4'b0001; tick();
            trig_in = '0;      tick();
        end
        repeat (10) tick();
        chk("pre_count", accepted_count - 32'(a0), 3);
        prescale[0 +: PW] = '0;
        a0 = int'(accepted_count);
        trig_in = 4'b0001;
        repeat (10) tick();
        trig_in = '0;
        repeat (6) tick();
        chk("level_one", accepted_count - 32'(a0), 1);

        // Round robin, two rounds
        do_reset();
        daq_busy = 1'b1;
        pulse(4'b1111);
        repeat (3) tick();
        chk("busy_hold", 32'(trig_valid), 0);
        daq_busy = 1'b0;
        nv = 0;
        for (int c = 0; c < 30 && nv < 4; c++) begin
            tick();
            if (trig_valid) begin
                rr_src[nv] = int'(trig_source);
                rr_msk[nv] = int'(trig_mask);
                nv++;
            end
        end
        pulse(4'b1111);
        for (int c = 0; c < 30 && nv < 8; c++) begin
            tick();
            if (trig_valid) begin
                rr_src[nv] = int'(trig_source);
                rr_msk[nv] = int'(trig_mask);
                nv++;
            end
        end
        chk("rr_grants", 32'(nv), 8);
        for (int r = 0; r < 8; r++) begin
            chk("rr_order", 32'(rr_src[r]), 32'(r % 4));
            chk("rr_mask", 32'(rr_msk[r]), 32'((4'b1111 << (r % 4)) & 4'b1111));
        end

        // Backpressure
        do_reset();
        trig_ready = 1'b0;
        pulse(4'b0010);
        wait_valid("bp_wait");
        s_hold = trig_source;
        m_hold = trig_mask;
        a0 = int'(accepted_count);
        chk("bp_source", 32'(s_hold), 1);
        chk("bp_mask", 32'(m_hold), 32'b0010);
        repeat (5) begin
            tick();
            chk("bp_valid_hold", 32'(trig_valid), 1);
            chk("bp_src_hold", 32'(trig_source), 32'(s_hold));
            chk("bp_mask_hold", 32'(trig_mask), 32'(m_hold));
            chk("bp_acc_hold", accepted_count, 32'(a0));
        end
        trig_ready = 1'b1;
        tick();
        chk("bp_acc_inc", accepted_count, 32'(a0 + 1));
        tick();
        chk("bp_valid_drop", 32'(trig_valid), 0);
        chk("bp_acc_once", accepted_count, 32'(a0 + 1));

        // Deadtime spacing and drops
        do_reset();
        deadtime = 16'd10;
        d0 = int'(dropped_count);
        hs_cyc.delete();
        for (int c = 0; c < 80; c++) begin
            trig_in = (c % 4 == 0) ? 4'b0010 : 4'b0000;
            tick();
            if (trig_valid) hs_cyc.push_back(c);
        end
        trig_in = '0;
        nh = hs_cyc.size();
        chk("dt_handshakes", 32'(nh >= 3), 1);
        for (int i = 1; i < nh; i++) begin
            gap = hs_cyc[i] - hs_cyc[i-1];
            chk("dt_gap_ge12", 32'(gap >= 12), 1);
        end
        chk("dt_drops", 32'(int'(dropped_count) > d0), 1);
        deadtime = '0;
        repeat (15) tick();

        // Reset mid-ISSUE
        do_reset();
        trig_ready = 1'b0;
        pulse(4'b1000);
        wait_valid("rm_wait");
        chk("rm_source", 32'(trig_source), 3);
        pulse(4'b1111);
        rst = 1'b1;
        tick();
        chk("rm_valid", 32'(trig_valid), 0);
        chk("rm_source0", 32'(trig_source), 0);
        chk("rm_mask0", 32'(trig_mask), 0);
        chk("rm_acc0", accepted_count, 0);
        chk("rm_drop0", dropped_count, 0);
        rst = 1'b0;
        tick();
        trig_ready = 1'b1;
        pulse(4'b1111);
        wait_valid("rm_wait2");
        chk("rm_first", 32'(trig_source), 0);
        repeat (12) tick();

        // Enable drop while pending
        do_reset();
        daq_busy = 1'b1;
        pulse(4'b1000);
        repeat (3) tick();
        enable = 4'b0111;
        tick();
        daq_busy = 1'b0;
        nv = 0;
        repeat (10) begin
            tick();
            if (trig_valid) nv++;
        end
        chk("en_no_request", 32'(nv), 0);
        enable = '1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            trig_in    = NS'($urandom) & NS'($urandom);
            daq_busy   = ($urandom_range(0, 4) == 0);
            trig_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) enable[$urandom_range(0, NS-1)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0)
                for (int i = 0; i < NS; i++) prescale[i*PW +: PW] = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) deadtime = DW'($urandom_range(0, 6));
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        trig_in = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
